mem_bus_resp: RTL and testbench
===============================

MEM_BUS_RESP -- requirements
Module: mem_bus_resp

Interface
REQ-001 SHALL have parameter MODULE_NUM, default 0, the memory module number this responder answers for on s (configure) cycles.
REQ-002 SHALL have parameter CPU_NUMBER, default 0, the PN value whose requests are served; requests with any other PN are ignored.
REQ-003 SHALL have one clock and an active-high asynchronous reset, as declared in REQ-004 and REQ-005.
REQ-004 SHALL have port clk_sys  in  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous reset, active high.
REQ-006 SHALL have port w  in  1  write request level, active high.
REQ-007 SHALL have port r  in  1  read request level, active high.
REQ-008 SHALL have port s  in  1  configure request level, active high.
REQ-009 SHALL have port nb  in  4  segment number (NB) driven by the CPU.
REQ-010 SHALL have port pn  in  1  processor number.
REQ-011 SHALL have port ad  in  16  logical address; ad[0:3] is the page and ad[4:15] the offset.
REQ-012 SHALL have port dt_in  in  16  data from the bus.
REQ-013 SHALL have port ok  out  1  acknowledge.
REQ-014 SHALL have port en  out  1  protocol refusal.
REQ-015 SHALL have port dt_out  out  16  read data.
REQ-016 SHALL have port dt_oe  out  1  read-data drive enable.
REQ-017 SHALL have port mem_a  out  16  frame address {frame[0:3], ad[4:15]}.
REQ-018 SHALL have port mem_d  out  16  write data.
REQ-019 SHALL have port mem_we  out  1  one-cycle write strobe.
REQ-020 SHALL have port mem_q  in  16  RAM read data, valid exactly 1 cycle after mem_a is presented.

Function
REQ-021 SHALL hold a 256-entry map indexed by {nb, page}, each entry being {valid, frame[0:3]}.
REQ-022 SHALL, when MODULE_NUM==0, treat entry {0,0} as permanently valid with frame 0; this hardwired entry overrides the table.
REQ-023 SHALL register w, r, s, nb, pn, ad and dt_in in IDLE on the first cycle on which any request is high (latch cycle L).
REQ-024 SHALL implement states IDLE, DECODE, READ, RESP and IGNORE.
REQ-025 SHALL move IDLE->DECODE at L.
REQ-026 SHALL, in DECODE, go to RESP with en=1 if more than one of the latched w/r/s is set.
REQ-027 SHALL, in DECODE, go to IGNORE if pn!=CPU_NUMBER.
REQ-028 SHALL, in DECODE for an r or w cycle, go to IGNORE if the map entry is invalid.
REQ-029 SHALL, in DECODE for a valid w, present mem_a and mem_d, pulse mem_we for that one cycle and go to RESP with ok=1.
REQ-030 SHALL, in DECODE for a valid r, present mem_a and go to READ.
REQ-031 SHALL, in READ, capture mem_q into dt_out and go to RESP with ok=1 and dt_oe=1.
REQ-032 SHALL handle an s cycle only if dt_in[4:7]==MODULE_NUM: it writes entry {dt_in[12:15], dt_in[0:3]} with valid=ad[15] and frame=dt_in[8:11], then goes to RESP with ok=1.
REQ-033 SHALL, for an s cycle whose dt_in[4:7]!=MODULE_NUM, go to IGNORE.
REQ-034 SHALL make a written map entry usable from the next request onward.
REQ-035 SHALL therefore give: ok at L+2 for w and s, ok with data at L+3 for r, en at L+2.
REQ-036 SHALL, in RESP, hold ok/en/dt_oe/dt_out stable until w, r and s are all low.
REQ-037 SHALL, on the cycle w, r and s are all low in RESP, clear ok/en/dt_oe and return to IDLE.
REQ-038 SHALL, in IGNORE, drive no response and return to IDLE once w, r and s are all low.
REQ-039 SHALL, on a request dropped before the response, still complete any mem_we already issued, then follow REQ-037/REQ-038.
REQ-040 SHALL never issue mem_we from any state other than DECODE.
REQ-041 SHALL register a new request only in IDLE; a request that stays high after a response is not re-served until it has been low for at least one cycle.
REQ-042 SHALL wrap the offset address within the frame, with no carry into frame bits.

Reset
REQ-043 SHALL, on reset=1 (asynchronous), force state IDLE, ok=0, en=0, dt_oe=0, mem_we=0, dt_out=0, mem_a=0 and mem_d=0.
REQ-044 SHALL, on reset, clear all map valid bits except the hardwired entry of REQ-022.
REQ-045 SHALL, on reset mid-cycle, abort the cycle with no response; if the request is still high after release, it is treated as a new request.

Verification
REQ-046 SHALL be verified by: after reset with MODULE_NUM=0, r with nb=0, ad=0x0123 -> mem_a=0x0123 at L+1, ok=1 and dt_out=mem_q at L+3.
REQ-047 SHALL be verified by: s with dt_in=0x2003 (page 2, module 0, frame 0, segment 3), ad[15]=1, followed by w with nb=3, ad=0x2ABC and dt_in=0x5555 -> ok at L+2, mem_we pulsed once with mem_a=0x0ABC and mem_d=0x5555.
REQ-048 SHALL be verified by: r to unmapped nb=5, page 7 -> no ok/en for 20 cycles; after r drops, the next valid request is served normally.
REQ-049 SHALL be verified by: r and w asserted together -> en=1 at L+2 and no mem_we; en clears the cycle after both drop.
REQ-050 SHALL be verified by: pn!=CPU_NUMBER -> ignored; and reset asserted in READ -> ok never asserts and all outputs are 0 immediately.

Source files
------------

// File: rtl/mem_bus_resp.sv
// Bus-side responder for one memory module: translates {segment, page} to a
// physical frame, runs read/write/configure bus cycles and answers with ok/en.
module mem_bus_resp #(
  parameter int MODULE_NUM = 0,
  parameter int CPU_NUMBER = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        w,
  input  logic        r,
  input  logic        s,
  input  logic [3:0]  nb,
  input  logic        pn,
  input  logic [15:0] ad,
  input  logic [15:0] dt_in,
  output logic        ok,
  output logic        en,
  output logic [15:0] dt_out,
  output logic        dt_oe,
  output logic [15:0] mem_a,
  output logic [15:0] mem_d,
  output logic        mem_we,
  input  logic [15:0] mem_q
);

  // Bus bit 0 is the MSB: ad[0:3] (page) maps to ad[15:12] here, and so on.
  localparam logic [3:0] MOD_ID    = 4'(MODULE_NUM);
  localparam logic       CPU_ID    = 1'(CPU_NUMBER);
  localparam bit         HARDWIRED = (MODULE_NUM == 0);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    RESP,
    IGNORE
  } state_t;

  state_t state_reg, state_next;

  logic        w_reg, r_reg, s_reg, pn_reg;
  logic [11:0] off_reg;
  logic [15:0] dt_reg;
  logic        hit_reg;
  logic [3:0]  frame_rd_reg;

  logic        ok_reg, ok_next;
  logic        en_reg, en_next;
  logic        dt_oe_reg, dt_oe_next;
  logic [15:0] dt_out_reg, dt_out_next;
  logic        mem_we_next;
  logic        map_we;

  logic [255:0] valid_reg;
  logic [3:0]   frame_mem [256];

  logic       any_req;
  logic       latch;
  logic       multi;
  logic [7:0] rd_idx;
  logic [7:0] wr_idx;
  logic       hard_hit;

  assign any_req  = w | r | s;
  assign latch    = (state_reg == IDLE) && any_req;
  assign multi    = (w_reg & r_reg) | (w_reg & s_reg) | (r_reg & s_reg);
  assign rd_idx   = {nb, ad[15:12]};
  assign wr_idx   = {dt_reg[3:0], dt_reg[15:12]};
  assign hard_hit = HARDWIRED && (rd_idx == 8'd0);

  // Request latch; the map lookup is done at the same edge so that the
  // frame is ready while DECODE presents the RAM address.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      w_reg        <= 1'b0;
      r_reg        <= 1'b0;
      s_reg        <= 1'b0;
      pn_reg       <= 1'b0;
      off_reg      <= '0;
      dt_reg       <= '0;
      hit_reg      <= 1'b0;
      frame_rd_reg <= '0;
    end else if (latch) begin
      w_reg        <= w;
      r_reg        <= r;
      s_reg        <= s;
      pn_reg       <= pn;
      off_reg      <= ad[11:0];
      dt_reg       <= dt_in;
      hit_reg      <= hard_hit | valid_reg[rd_idx];
      frame_rd_reg <= hard_hit ? 4'd0 : frame_mem[rd_idx];
    end
  end

  // Valid bits need a reset; frame numbers live in plain RAM.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (map_we) begin
      valid_reg[wr_idx] <= off_reg[0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (map_we) begin
      frame_mem[wr_idx] <= dt_reg[7:4];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ok_reg     <= 1'b0;
      en_reg     <= 1'b0;
      dt_oe_reg  <= 1'b0;
      dt_out_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ok_reg     <= ok_next;
      en_reg     <= en_next;
      dt_oe_reg  <= dt_oe_next;
      dt_out_reg <= dt_out_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ok_next     = ok_reg;
    en_next     = en_reg;
    dt_oe_next  = dt_oe_reg;
    dt_out_next = dt_out_reg;
    mem_we_next = 1'b0;
    map_we      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (multi) begin
          en_next    = 1'b1;
          state_next = RESP;
        end else if (pn_reg != CPU_ID) begin
          state_next = IGNORE;
        end else if (s_reg) begin
          if (dt_reg[11:8] == MOD_ID) begin
            map_we     = 1'b1;
            ok_next    = 1'b1;
            state_next = RESP;
          end else begin
            state_next = IGNORE;
          end
        end else if (!hit_reg) begin
          state_next = IGNORE;
        end else if (w_reg) begin
          mem_we_next = 1'b1;
          ok_next     = 1'b1;
          state_next  = RESP;
        end else begin
          state_next = READ;
        end
      end
      READ: begin
        dt_out_next = mem_q;
        ok_next     = 1'b1;
        dt_oe_next  = 1'b1;
        state_next  = RESP;
      end
      RESP: begin
        // Response stays up until the bus drops every request line.
        if (!any_req) begin
          ok_next    = 1'b0;
          en_next    = 1'b0;
          dt_oe_next = 1'b0;
          state_next = IDLE;
        end
      end
      IGNORE: begin
        if (!any_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Offset passes straight through, so page wrap never carries into the frame.
  assign mem_a  = {frame_rd_reg, off_reg};
  assign mem_d  = dt_reg;
  assign mem_we = mem_we_next;
  assign ok     = ok_reg;
  assign en     = en_reg;
  assign dt_oe  = dt_oe_reg;
  assign dt_out = dt_out_reg;

endmodule

// File: tb/tb_mem_bus_resp.sv
// Directed plus randomized bus cycles against a map/RAM reference model.
module tb_mem_bus_resp;

  localparam logic [3:0] MOD = 4'd0;
  localparam logic       CPU = 1'b0;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        w, r, s, pn;
  logic [3:0]  nb;
  logic [15:0] ad, dt_in;
  logic        ok, en, dt_oe, mem_we;
  logic [15:0] dt_out, mem_a, mem_d;
  logic [15:0] mem_q;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  logic [15:0] ram       [65536];
  logic [15:0] model_ram [65536];
  bit          mvalid    [256];
  logic [3:0]  mframe    [256];

  logic        tw, tr, ts, tpn;
  logic [3:0]  tnb;
  logic [15:0] tad, tdt;

  mem_bus_resp #(.MODULE_NUM(0), .CPU_NUMBER(0)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .w      (w),
    .r      (r),
    .s      (s),
    .nb     (nb),
    .pn     (pn),
    .ad     (ad),
    .dt_in  (dt_in),
    .ok     (ok),
    .en     (en),
    .dt_out (dt_out),
    .dt_oe  (dt_oe),
    .mem_a  (mem_a),
    .mem_d  (mem_d),
    .mem_we (mem_we),
    .mem_q  (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_a] <= mem_d;
    mem_q <= ram[mem_a];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
  endtask

  // Called at a negedge; drives one bus cycle, watches the response, then drops it.
  task automatic run_txn(input logic xw, input logic xr, input logic xs, input logic [3:0] xnb,
                         input logic xpn, input logic [15:0] xad, input logic [15:0] xdt);
    int          n, lat, nwait, first_ok, first_en, we_cnt;
    logic        exp_ok, exp_en, exp_oe, exp_we, v;
    logic [3:0]  f;
    logic [7:0]  idx;
    logic [15:0] exp_a, exp_q, a1, got_a, got_d, dq;
    n = int'(xw) + int'(xr) + int'(xs);
    exp_ok = 0; exp_en = 0; exp_oe = 0; exp_we = 0; exp_a = '0; exp_q = '0; lat = 0;
    if (n > 1) begin
      exp_en = 1'b1;
    end else if (xpn != CPU) begin
      exp_ok = 1'b0;
    end else if (xs) begin
      if (xdt[11:8] == MOD) begin exp_ok = 1'b1; lat = 2; end
    end else begin
      idx = {xnb, xad[15:12]};
      v = (MOD == 0 && idx == 0) ? 1'b1 : mvalid[idx];
      f = (MOD == 0 && idx == 0) ? 4'd0 : mframe[idx];
      if (v) begin
        exp_ok = 1'b1;
        exp_a  = {f, xad[11:0]};
        if (xw) begin exp_we = 1'b1; lat = 2; end
        else begin exp_oe = 1'b1; lat = 3; exp_q = model_ram[exp_a]; end
      end
    end
    nwait = (exp_ok || exp_en) ? 6 : 20;

    w = xw; r = xr; s = xs; nb = xnb; pn = xpn; ad = xad; dt_in = xdt;
    first_ok = 0; first_en = 0; we_cnt = 0; a1 = '0; got_a = '0; got_d = '0; dq = '0;
    for (int k = 1; k <= nwait; k++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      if (k == 1) a1 = mem_a;
      if (mem_we) begin we_cnt++; got_a = mem_a; got_d = mem_d; end
      if (ok && first_ok == 0) begin first_ok = k; dq = dt_out; end
      if (en && first_en == 0) first_en = k;
    end
    chk("ok_latency", 64'(first_ok), 64'(exp_ok ? lat : 0));
    chk("en_latency", 64'(first_en), 64'(exp_en ? 2 : 0));
    chk("we_count", 64'(we_cnt), 64'(exp_we));
    chk("hold", {ok, en, dt_oe}, {exp_ok, exp_en, exp_oe});
    if (exp_ok && !xs) chk("mem_a_L1", a1, exp_a);
    if (exp_we) begin
      chk("we_addr", got_a, exp_a);
      chk("we_data", got_d, xdt);
    end
    if (exp_oe) chk("dt_out", dq, exp_q);

    w = 0; r = 0; s = 0;
    @(posedge clk_sys); @(negedge clk_sys);
    chk("clear", {ok, en, dt_oe, mem_we}, 4'b0000);
    @(posedge clk_sys); @(negedge clk_sys);

    if (xs && exp_ok) begin
      mvalid[{xdt[3:0], xdt[15:12]}] = xad[0];
      mframe[{xdt[3:0], xdt[15:12]}] = xdt[7:4];
    end
    if (exp_we) model_ram[exp_a] = xdt;
    txn_no++;
    $display("txn %0d w=%0b r=%0b s=%0b nb=%h pn=%0b ad=%h dt=%h ok@%0d en@%0d we=%0d dt_out=%h",
             txn_no, xw, xr, xs, xnb, xpn, xad, xdt, first_ok, first_en, we_cnt, dq);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]       = 16'(i * 37) ^ 16'h5A5A;
      model_ram[i] = 16'(i * 37) ^ 16'h5A5A;
    end
    model_reset();
    w = 0; r = 0; s = 0; nb = '0; pn = 0; ad = '0; dt_in = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("reset_outs", {ok, en, dt_oe, mem_we, dt_out, mem_a, mem_d}, 52'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    run_txn(0, 1, 0, 4'd0, 0, 16'h0123, 16'h0000);  // hardwired entry read
    run_txn(0, 0, 1, 4'd0, 0, 16'h0001, 16'h2003);  // map seg3 page2 -> frame0
    run_txn(1, 0, 0, 4'd3, 0, 16'h2ABC, 16'h5555);
    run_txn(0, 1, 0, 4'd3, 0, 16'h2ABC, 16'h0000);
    run_txn(0, 1, 0, 4'd5, 0, 16'h7000, 16'h0000);  // unmapped
    run_txn(0, 1, 0, 4'd0, 0, 16'h0FFF, 16'h0000);
    run_txn(1, 1, 0, 4'd0, 0, 16'h0010, 16'h1234);  // refusal
    run_txn(0, 1, 0, 4'd0, 1, 16'h0010, 16'h0000);  // foreign CPU
    run_txn(0, 0, 1, 4'd0, 0, 16'h0001, 16'h2103);  // other module
    run_txn(0, 0, 1, 4'd0, 0, 16'h0001, 16'h10F4);  // seg4 page1 -> frameF
    run_txn(1, 0, 0, 4'd4, 0, 16'h1FFF, 16'hBEEF);  // top of frame, no carry
    run_txn(0, 0, 1, 4'd0, 0, 16'h0000, 16'h2003);  // invalidate seg3 page2
    run_txn(0, 1, 0, 4'd3, 0, 16'h2000, 16'h0000);

    // Reset while in READ, request held across it.
    r = 1; nb = 4'd0; pn = 0; ad = 16'h0456; dt_in = '0;
    repeat (2) begin @(posedge clk_sys); @(negedge clk_sys); end
    reset = 1'b1;
    #1;
    chk("reset_in_read", {ok, en, dt_oe, mem_we, dt_out, mem_a, mem_d}, 52'd0);
    @(posedge clk_sys); @(negedge clk_sys);
    chk("reset_no_ok", {ok, en}, 2'b00);
    reset = 1'b0;
    model_reset();
    run_txn(0, 1, 0, 4'd0, 0, 16'h0456, 16'h0000);
    run_txn(0, 1, 0, 4'd4, 0, 16'h1000, 16'h0000);  // map cleared by reset

    for (int t = 0; t < 40; t++) begin
      int op;
      op = int'($urandom_range(0, 9));
      tw = 0; tr = 0; ts = 0;
      tpn = ($urandom_range(0, 9) == 0);
      tnb = 4'($urandom_range(0, 3));
      tad = 16'($urandom);
      tad[15:12] = 4'($urandom_range(0, 3));
      tdt = 16'($urandom);
      case (op)
        0, 1: begin
          ts = 1;
          tdt[15:12] = 4'($urandom_range(0, 3));
          tdt[11:8]  = ($urandom_range(0, 5) == 0) ? 4'h1 : 4'h0;
          tdt[3:0]   = 4'($urandom_range(0, 3));
          if ($urandom_range(0, 3) != 0) tad[0] = 1'b1;
        end
        2, 3, 4: tw = 1;
        5, 6, 7: tr = 1;
        8: begin tw = 1; tr = 1'($urandom_range(0, 1)); ts = ~tr; end
        default: begin tr = 1; tnb = 4'($urandom); tad = 16'($urandom); end
      endcase
      run_txn(tw, tr, ts, tnb, tpn, tad, tdt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
